inst_mem_resp: RTL and testbench

- Bus responder (target side) for the CPU instruction-fetch read interface.
- Accepts single-cycle read request pulses and returns exactly one registered read-valid pulse with data per accepted request, after a fixed latency.
- Backed by an internal synchronous word SRAM that a debug/UART program loader fills through a separate write port.
- Sits between the fetch stage's read initiator and on-chip instruction RAM.

---
 rtl/inst_mem_resp.sv | 171 +++++++++++++++++
 tb/tb_inst_mem_resp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
// Instruction-fetch read responder backed by a loader-filled word SRAM.
// One registered valid pulse per accepted request after a fixed latency.
module inst_mem_resp #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read_req,
  input  logic              i_read_w,
  input  logic              i_read_hw,
  input  logic [31:0]       i_read_adr,
  output logic              i_read_valid,
  output logic [31:0]       i_read_data,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ready,
  output logic              busy,
  output logic              req_ovf
);

  localparam int AW = ADDR_W + 2;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  localparam state_t START = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] adr_q;
  logic [AW-1:0] adr_d;
  logic          w_q;
  logic          w_d;
  logic          hw_q;
  logic          hw_d;
  logic          pend_v_q;
  logic [AW-1:0] pend_adr_q;
  logic          pend_w_q;
  logic          pend_hw_q;
  logic          valid_q;
  logic [31:0]   data_q;
  logic          ovf_q;
  logic [31:0]   rd_q;
  logic [31:0]   fmt;
  logic          load_pend;
  logic          load_req;
  logic          pend_wr;
  logic          unused_hi;

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  assign unused_hi    = ^i_read_adr[31:AW];
  assign i_read_valid = valid_q;
  assign i_read_data  = data_q;
  assign req_ovf      = ovf_q;
  assign busy         = (state_q != S_IDLE) | pend_v_q;
  assign ld_ready     = (state_q == S_IDLE) & ~pend_v_q
                      & ~i_read_req;

  // Pick the source of the next active transaction.
  always_comb begin
    load_pend = (state_q == S_ACCESS) & pend_v_q;
    load_req  = i_read_req
              & ((state_q == S_IDLE)
              | ((state_q == S_ACCESS) & ~pend_v_q));
    pend_wr   = i_read_req & ~load_req;
    adr_d     = adr_q;
    w_d       = w_q;
    hw_d      = hw_q;
    if (load_pend) begin
      adr_d = pend_adr_q;
      w_d   = pend_w_q;
      hw_d  = pend_hw_q;
    end else if (load_req) begin
      adr_d = i_read_adr[AW-1:0];
      w_d   = i_read_w;
      hw_d  = i_read_hw;
    end
  end

  // Lane select and zero-extension of the SRAM word.
  always_comb begin
    fmt = 32'h0;
    unique case (1'b1)
      w_q:
        fmt = rd_q;
      (~w_q & hw_q):
        fmt = {16'h0, adr_q[1] ? rd_q[31:16]
                               : rd_q[15:0]};
      (~w_q & ~hw_q):
        fmt = {24'h0, rd_q[{adr_q[1:0], 3'b000} +: 8]};
      default:
        fmt = 32'h0;
    endcase
  end

  // SRAM: loader write and read of the upcoming active index.
  always_ff @(posedge clk) begin
    if (ld_we & ld_ready) begin
      mem_q[ld_adr] <= ld_wdata;
    end
    rd_q <= mem_q[adr_d[AW-1:2]];
  end

  // Transaction FSM, pending slot and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      adr_q      <= '0;
      w_q        <= 1'b0;
      hw_q       <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_adr_q <= '0;
      pend_w_q   <= 1'b0;
      pend_hw_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'h0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      adr_q   <= adr_d;
      w_q     <= w_d;
      hw_q    <= hw_d;
      if (pend_wr) begin
        pend_v_q   <= 1'b1;
        pend_adr_q <= i_read_adr[AW-1:0];
        pend_w_q   <= i_read_w;
        pend_hw_q  <= i_read_hw;
        if (pend_v_q & ~load_pend) begin
          ovf_q <= 1'b1;
        end
      end else if (load_pend) begin
        pend_v_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (load_req) begin
            state_q <= START;
            cnt_q   <= WC;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          valid_q <= 1'b1;
          data_q  <= fmt;
          if (load_pend | load_req) begin
            state_q <= START;
            cnt_q   <= WC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances with 0, 2 and 3 wait states.
// Expected responses are queued at drive time and popped on valid.
module tb_inst_mem_resp;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req      [3];
  logic        w        [3];
  logic        hw       [3];
  logic [31:0] adr      [3];
  logic        valid    [3];
  logic [31:0] data     [3];
  logic        ld_we    [3];
  logic [11:0] ld_adr   [3];
  logic [31:0] ld_wdata [3];
  logic        ld_ready [3];
  logic        busy     [3];
  logic        ovf      [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inst_mem_resp #(
      .ADDR_W(12),
      .WAIT_CYCLES(g == 0 ? 0 : g + 1)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_read_req(req[g]),
      .i_read_w(w[g]),
      .i_read_hw(hw[g]),
      .i_read_adr(adr[g]),
      .i_read_valid(valid[g]),
      .i_read_data(data[g]),
      .ld_we(ld_we[g]),
      .ld_adr(ld_adr[g]),
      .ld_wdata(ld_wdata[g]),
      .ld_ready(ld_ready[g]),
      .busy(busy[g]),
      .req_ovf(ovf[g])
    );
  end

  function automatic int wc(input int i);
    case (i)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int qsz(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push(input int i,
                               input logic [31:0] d,
                               input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input int i,
                    input logic [11:0] idx,
                    input logic [31:0] d);
    ld_we[i]    = 1'b1;
    ld_adr[i]   = idx;
    ld_wdata[i] = d;
    #1;
    chk($sformatf("u%0d_ld_ready", i), 32'(ld_ready[i]), 1);
    tick();
    ld_we[i] = 1'b0;
  endtask

  task automatic rd(input int i,
                    input logic [31:0] a,
                    input logic ww,
                    input logic hh,
                    input logic [31:0] d);
    req[i] = 1'b1;
    adr[i] = a;
    w[i]   = ww;
    hw[i]  = hh;
    push(i, d, cyc + 2 + wc(i));
    tick();
    req[i] = 1'b0;
  endtask

  task automatic drain(input int i, input string tag);
    for (int k = 0; k < 64; k++) begin
      if (qsz(i) == 0 && busy[i] == 1'b0) break;
      tick();
    end
    chk({tag, "_drain"},
        32'(qsz(i) == 0 && busy[i] == 1'b0), 1);
  endtask

  // Pop and compare every valid pulse against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i] === 1'b1) begin
        chk($sformatf("u%0d_expected_pulse", i),
            32'(qsz(i) > 0), 1);
        if (qsz(i) > 0) begin
          mon_e = pop(i);
          chk($sformatf("u%0d_data", i), data[i], mon_e.d);
          chk($sformatf("u%0d_cycle", i),
              32'(cyc), 32'(mon_e.c));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i]      = 1'b0;
      w[i]        = 1'b0;
      hw[i]       = 1'b0;
      adr[i]      = 32'h0;
      ld_we[i]    = 1'b0;
      ld_adr[i]   = 12'h0;
      ld_wdata[i] = 32'h0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_valid", i), 32'(valid[i]), 0);
      chk($sformatf("u%0d_rst_data", i), data[i], 0);
      chk($sformatf("u%0d_rst_ovf", i), 32'(ovf[i]), 0);
      chk($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 0);
    end
    rst_n = 1'b1;
    tick();

    // zero wait states: latency 2, data held afterwards
    ld(0, 12'd4, 32'h0000_0013);
    ld(0, 12'd0, 32'hA1B2_C3D4);
    rd(0, 32'h10, 1'b1, 1'b0, 32'h0000_0013);
    drain(0, "w0_word");
    repeat (3) tick();
    chk("w0_hold_data", data[0], 32'h0000_0013);
    chk("w0_hold_valid", 32'(valid[0]), 0);

    // sub-word formatting and aliasing, back-to-back
    rd(0, 32'h2, 1'b0, 1'b1, 32'h0000_A1B2);
    rd(0, 32'h1, 1'b0, 1'b0, 32'h0000_00C3);
    rd(0, 32'h3, 1'b1, 1'b0, 32'hA1B2_C3D4);
    rd(0, 32'h3, 1'b0, 1'b0, 32'h0000_00A1);
    rd(0, 32'h1, 1'b0, 1'b1, 32'h0000_C3D4);
    rd(0, 32'h4010, 1'b1, 1'b0, 32'h0000_0013);
    drain(0, "w0_sub");

    // three wait states: latency 5, new request in valid cycle
    ld(2, 12'd7, 32'h0000_0077);
    ld(2, 12'd8, 32'h0000_0088);
    rd(2, 32'h1C, 1'b1, 1'b0, 32'h0000_0077);
    repeat (4) tick();
    chk("w3_idle_in_valid_cycle", 32'(busy[2]), 0);
    rd(2, 32'h20, 1'b1, 1'b0, 32'h0000_0088);
    drain(2, "w3");

    // two wait states: pending slot overwrite
    ld(1, 12'd1, 32'h0000_0111);
    ld(1, 12'd2, 32'h0000_0222);
    ld(1, 12'd3, 32'h0000_0333);
    req[1] = 1'b1;
    w[1]   = 1'b1;
    hw[1]  = 1'b0;
    adr[1] = 32'h4;
    push(1, 32'h0000_0111, cyc + 4);
    tick();
    adr[1] = 32'h8;
    tick();
    #1;
    chk("w2_ovf_before", 32'(ovf[1]), 0);
    adr[1] = 32'hC;
    push(1, 32'h0000_0333, cyc + 5);
    tick();
    req[1] = 1'b0;
    drain(1, "w2_ovf");
    chk("w2_ovf_after", 32'(ovf[1]), 1);
    chk("w3_no_ovf", 32'(ovf[2]), 0);

    // loader held while a fetch is in flight
    ld_we[1]    = 1'b1;
    ld_adr[1]   = 12'd5;
    ld_wdata[1] = 32'hCAFE_F00D;
    req[1]      = 1'b1;
    adr[1]      = 32'h4;
    w[1]        = 1'b1;
    push(1, 32'h0000_0111, cyc + 4);
    #1;
    chk("ld_blocked_req", 32'(ld_ready[1]), 0);
    tick();
    req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ld_blocked_busy%0d", k),
          32'(ld_ready[1]), 0);
      tick();
    end
    #1;
    chk("ld_ready_first_idle", 32'(ld_ready[1]), 1);
    tick();
    ld_we[1] = 1'b0;
    rd(1, 32'h14, 1'b1, 1'b0, 32'hCAFE_F00D);
    drain(1, "ld_new");

    // reset during ACCESS abandons the fetch
    req[0] = 1'b1;
    adr[0] = 32'h0;
    w[0]   = 1'b1;
    tick();
    req[0] = 1'b0;
    chk("rst_in_access_busy", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #2;
    chk("rst_async_data", data[0], 0);
    chk("rst_async_valid", 32'(valid[0]), 0);
    chk("rst_async_ovf", 32'(ovf[1]), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_after_data", data[0], 0);
    chk("rst_after_busy", 32'(busy[0]), 0);
    chk("rst_after_ovf", 32'(ovf[1]), 0);

    // SRAM survives reset
    rd(0, 32'h10, 1'b1, 1'b0, 32'h0000_0013);
    rd(1, 32'h14, 1'b1, 1'b0, 32'hCAFE_F00D);
    drain(0, "post_rst_u0");
    drain(1, "post_rst_u1");

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_sb_empty", i), 32'(qsz(i)), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
